// File: rtl/dual_issue_forward_ctrl.sv
// Execute-stage forwarding control for a dual-issue pipeline: tracks M/W destinations,
// produces W-stage forward selects, a one-cycle load-use style stall, and a stall counter.
module dual_issue_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1A_E,
  input  logic [REG_AW-1:0] Rs2A_E,
  input  logic [REG_AW-1:0] Rs1B_E,
  input  logic [REG_AW-1:0] Rs2B_E,
  input  logic [REG_AW-1:0] RdA_E,
  input  logic [REG_AW-1:0] RdB_E,
  input  logic              RegWriteA_E,
  input  logic              RegWriteB_E,
  input  logic              FlushE,
  output logic [1:0]        ForwardA1E,
  output logic [1:0]        ForwardA2E,
  output logic [1:0]        ForwardB1E,
  output logic [1:0]        ForwardB2E,
  output logic              StallE,
  output logic              BubbleM,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_A_W = 2'b01,
    FWD_B_W = 2'b10
  } fwd_sel_e;

  // Destination record of one issue bundle as it moves through M and W.
  typedef struct packed {
    logic              wr_a;
    logic              wr_b;
    logic [REG_AW-1:0] rd_a;
    logic [REG_AW-1:0] rd_b;
  } dest_t;

  dest_t            r_m;
  dest_t            r_w;
  logic [CNT_W-1:0] r_stall_count;

  dest_t            w_e_dest;
  logic             w_dep_m;
  logic             w_stall;
  logic             w_bubble;
  fwd_sel_e         w_fwd_a1;
  fwd_sel_e         w_fwd_a2;
  fwd_sel_e         w_fwd_b1;
  fwd_sel_e         w_fwd_b2;

  // Register x0 is hardwired zero, so it can neither produce nor consume a result.
  function automatic logic hits(input logic [REG_AW-1:0] src,
                                input logic              wr,
                                input logic [REG_AW-1:0] rd);
    return wr && (src != '0) && (rd == src);
  endfunction

  // Slot B is the younger instruction of a bundle, so its result takes priority.
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] src, input dest_t w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hits(src, w.wr_b, w.rd_b))      sel = FWD_B_W;
    else if (hits(src, w.wr_a, w.rd_a)) sel = FWD_A_W;
    return sel;
  endfunction

  function automatic logic dep_on(input logic [REG_AW-1:0] src, input dest_t m);
    return hits(src, m.wr_a, m.rd_a) || hits(src, m.wr_b, m.rd_b);
  endfunction

  // NOTE: every signal written in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    w_fwd_a1 = fwd_sel(Rs1A_E, r_w);
    w_fwd_a2 = fwd_sel(Rs2A_E, r_w);
    w_fwd_b1 = fwd_sel(Rs1B_E, r_w);
    w_fwd_b2 = fwd_sel(Rs2B_E, r_w);

    w_dep_m  = dep_on(Rs1A_E, r_m) || dep_on(Rs2A_E, r_m) ||
               dep_on(Rs1B_E, r_m) || dep_on(Rs2B_E, r_m);
    w_stall  = w_dep_m && !FlushE;
    w_bubble = w_stall || FlushE;

    w_e_dest = '{wr_a: RegWriteA_E, wr_b: RegWriteB_E, rd_a: RdA_E, rd_b: RdB_E};
    if (w_bubble) begin
      w_e_dest.wr_a = 1'b0;
      w_e_dest.wr_b = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m           <= '0;
      r_w           <= '0;
      r_stall_count <= '0;
    end else begin
      r_w <= r_m;
      r_m <= w_e_dest;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign ForwardA1E = w_fwd_a1;
  assign ForwardA2E = w_fwd_a2;
  assign ForwardB1E = w_fwd_b1;
  assign ForwardB2E = w_fwd_b2;
  assign StallE     = w_stall;
  assign BubbleM    = w_bubble;
  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_dual_issue_forward_ctrl.sv
// Self-checking bench: directed vector table, random run against a bundle-history model,
// and hand-written saturation / reset-during-stall sequences.
module tb_dual_issue_forward_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] rs1a, rs2a, rs1b, rs2b, rda, rdb;
  logic              wa, wb, flush;
  logic [1:0]        fa1, fa2, fb1, fb2;
  logic              stall, bubble;
  logic [CNT_W-1:0]  cnt;

  int n_pass  = 0;
  int n_total = 0;

  dual_issue_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1A_E(rs1a), .Rs2A_E(rs2a), .Rs1B_E(rs1b), .Rs2B_E(rs2b),
    .RdA_E(rda), .RdB_E(rdb), .RegWriteA_E(wa), .RegWriteB_E(wb), .FlushE(flush),
    .ForwardA1E(fa1), .ForwardA2E(fa2), .ForwardB1E(fb1), .ForwardB2E(fb2),
    .StallE(stall), .BubbleM(bubble), .StallCount(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int rs1a, rs2a, rs1b, rs2b, rda, rdb;
    bit wa, wb, flush;
    int e_fa1, e_fa2, e_fb1, e_fb2;
    bit e_stall, e_bubble;
    int e_cnt;
  } vec_t;

  function automatic vec_t mk(int rs1a_, int rs2a_, int rs1b_, int rs2b_, int rda_, int rdb_,
                              bit wa_, bit wb_, bit fl_, int a1, int a2, int b1, int b2,
                              bit st, bit bu, int c);
    vec_t v;
    v.rs1a = rs1a_; v.rs2a = rs2a_; v.rs1b = rs1b_; v.rs2b = rs2b_;
    v.rda = rda_; v.rdb = rdb_; v.wa = wa_; v.wb = wb_; v.flush = fl_;
    v.e_fa1 = a1; v.e_fa2 = a2; v.e_fb1 = b1; v.e_fb2 = b2;
    v.e_stall = st; v.e_bubble = bu; v.e_cnt = c;
    return v;
  endfunction

  task automatic drive(int s1a, int s2a, int s1b, int s2b, int da, int db,
                       bit w_a, bit w_b, bit fl);
    rs1a = REG_AW'(s1a); rs2a = REG_AW'(s2a); rs1b = REG_AW'(s1b); rs2b = REG_AW'(s2b);
    rda = REG_AW'(da); rdb = REG_AW'(db); wa = w_a; wb = w_b; flush = fl;
  endtask

  task automatic check_all(string tag, int a1, int a2, int b1, int b2, bit st, bit bu, int c);
    check({tag, ".fa1"}, int'(fa1), a1);
    check({tag, ".fa2"}, int'(fa2), a2);
    check({tag, ".fb1"}, int'(fb1), b1);
    check({tag, ".fb2"}, int'(fb2), b2);
    check({tag, ".stall"}, int'(stall), int'(st));
    check({tag, ".bubble"}, int'(bubble), int'(bu));
    check({tag, ".cnt"}, int'(cnt), c);
  endtask

  // Apply reset with Rs1A_E=5 presented; outputs must be idle during reset. Releases at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post_reset", 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: history of bundles that have entered the pipeline after E.
  typedef struct { bit wa, wb; int rda, rdb; } wr_t;
  wr_t hist[$];
  int  m_cnt;

  function automatic int exp_fwd(int s, wr_t w);
    if (s == 0) return 0;
    if (w.wb && w.rdb == s) return 2;
    if (w.wa && w.rda == s) return 1;
    return 0;
  endfunction

  function automatic bit in_flight(int s, wr_t m);
    return (s != 0) && ((m.wa && m.rda == s) || (m.wb && m.rdb == s));
  endfunction

  task automatic model_clear();
    wr_t e;
    e = '{0, 0, 0, 0};
    hist = {};
    hist.push_back(e);
    hist.push_back(e);
    m_cnt = 0;
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rs1a rs2a rs1b rs2b rda rdb wa wb fl  a1 a2 b1 b2 st bu cnt
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 4, 4, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 2));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].rs1a, tbl[i].rs2a, tbl[i].rs1b, tbl[i].rs2b, tbl[i].rda, tbl[i].rdb,
            tbl[i].wa, tbl[i].wb, tbl[i].flush);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].e_fa1, tbl[i].e_fa2, tbl[i].e_fb1, tbl[i].e_fb2,
                tbl[i].e_stall, tbl[i].e_bubble, tbl[i].e_cnt);
    end

    // Random traffic against the bundle-history model.
    do_reset();
    model_clear();
    for (int i = 0; i < 400; i++) begin
      int s[4];
      wr_t e, m, w;
      bit dep, e_st, e_bu;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) s[k] = int'($urandom_range(0, 7));
      e.rda = int'($urandom_range(0, 7));
      e.rdb = int'($urandom_range(0, 7));
      e.wa  = bit'($urandom_range(0, 1));
      e.wb  = bit'($urandom_range(0, 1));
      drive(s[0], s[1], s[2], s[3], e.rda, e.rdb, e.wa, e.wb, ($urandom_range(0, 7) == 0));
      m = hist[0];
      w = hist[1];
      dep = 1'b0;
      for (int k = 0; k < 4; k++) if (in_flight(s[k], m)) dep = 1'b1;
      e_st = dep && !flush;
      e_bu = e_st || flush;
      @(negedge clk);
      check_all($sformatf("rnd%0d", i), exp_fwd(s[0], w), exp_fwd(s[1], w),
                exp_fwd(s[2], w), exp_fwd(s[3], w), e_st, e_bu, m_cnt);
      if (e_bu) begin
        e.wa = 1'b0;
        e.wb = 1'b0;
      end
      hist.push_front(e);
      void'(hist.pop_back());
      if (e_st && m_cnt < (2**CNT_W - 1)) m_cnt++;
    end

    // Self-dependent bundle held in E: stalls every other cycle, 20 stalls saturate at 15.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
    end
    @(negedge clk);
    check("sat_count", int'(cnt), 2**CNT_W - 1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        @(posedge clk);
        @(negedge clk);
        seen = stall;
      end
      check("sat_stall_seen", int'(seen), 1);
    end
    check("sat_hold_in_stall", int'(cnt), 2**CNT_W - 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall.stall", int'(stall), 0);
    check("rst_mid_stall.bubble", int'(bubble), 0);
    check("rst_mid_stall.cnt", int'(cnt), 0);
    check("rst_mid_stall.fa1", int'(fa1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_rst.stall", int'(stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dual_issue_forward_ctrl.md
Name: dual_issue_forward_ctrl

Overview:
- Control end of the dual-issue execute-stage operand forwarding path.
- Generates the four 2-bit select codes consumed by the slot A/B operand forwarding muxes:
  - 00 = register-file read data
  - 01 = ResultA_W
  - 10 = ResultB_W
- Forwarding is available from writeback only. The block therefore keeps its own M/W destination pipeline and raises a one-cycle execute stall when an E-stage source depends on an instruction still in M.
- Also counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall performance counter width

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- Rs1A_E  input  REG_AW  slot A source 1 in E
- Rs2A_E  input  REG_AW  slot A source 2 in E
- Rs1B_E  input  REG_AW  slot B source 1 in E
- Rs2B_E  input  REG_AW  slot B source 2 in E
- RdA_E  input  REG_AW  slot A destination in E
- RdB_E  input  REG_AW  slot B destination in E
- RegWriteA_E  input  1  slot A writes register file
- RegWriteB_E  input  1  slot B writes register file
- FlushE  input  1  squash both E-stage instructions (branch redirect)
- ForwardA1E  output  2  slot A source 1 select
- ForwardA2E  output  2  slot A source 2 select
- ForwardB1E  output  2  slot B source 1 select
- ForwardB2E  output  2  slot B source 2 select
- StallE  output  1  hold E/D/F pipeline registers this cycle
- BubbleM  output  1  load NOP into E/M register this cycle
- StallCount  output  CNT_W  saturating count of stall cycles

Behaviour:
- Internal state (registered):
  - M stage: RdA_M, RdB_M, WrA_M, WrB_M
  - W stage: RdA_W, RdB_W, WrA_W, WrB_W
  - counter: StallCount
- Reset (async, rst_n low):
  - all Wr*_M and Wr*_W = 0; Rd* = 0; StallCount = 0
  - hence Forward* = 00, StallE = 0, BubbleM = 0 while in reset and on the first cycle after release
- Reg x0 rule: a source or destination equal to 0 never matches. It produces no forward and no stall.
- Forward select, combinational from E sources vs W state, per source S:
  - match on B (WrB_W && RdB_W == S) -> 10. Slot B is younger, so B wins when both W slots target S.
  - else match on A (WrA_W && RdA_W == S) -> 01
  - else 00
- Stall detect, combinational:
  - depM = any of the four E sources equals RdA_M with WrA_M, or RdB_M with WrB_M.
  - StallE = depM && !FlushE
- BubbleM = StallE || FlushE.
- Pipeline advance, every posedge:
  - W <= M (always, no stall input on W).
  - M <= E destinations/RegWrite if !BubbleM; else WrA_M = WrB_M = 0 (Rd values don't care).
- Stall timing:
  - A dependency on M stalls exactly one cycle. In the next cycle the producer is in W and the source forwards with 01/10.
  - Back-to-back stalls can only arise from a new dependency; they never arise from the same producer.
- Forward select during a stall cycle is still computed and driven; the muxes' output is discarded by the held E register.
- Intra-bundle RAW (slot B reading slot A's Rd in the same E bundle) is excluded by the issue stage. This block does not check it.
- Register file writes in W on the falling edge, so D-stage reads see W results. No D-stage forwarding is required.
- StallCount increments by 1 on each posedge where StallE = 1 and saturates at all-ones (no wrap).
- FlushE with a pending M dependency: flush wins. No stall, bubble inserted, counter unchanged.
- Reset asserted mid-stall:
  - state clears immediately
  - StallE drops asynchronously
  - StallCount returns to 0

Test Plan:
- Reset, then E: Rs1A_E=5, all W/M empty -> all Forward*=00, StallE=0, StallCount=0.
- Cycle n: E has RdA_E=7, RegWriteA_E=1; filler with no dependency in n+1; n+2: Rs2B_E=7 -> ForwardB2E=10? no, ForwardB2E=01, StallE=0.
- Both slots write x9 (A and B), two cycles later Rs1A_E=9 -> ForwardA1E=10 (B priority).
- Producer RdB_E=3 in cycle n; consumer Rs1A_E=3 in n+1:
  - n+1: StallE=1, BubbleM=1
  - n+2: StallE=0, ForwardA1E=10
  - StallCount=1
- Same as previous but FlushE=1 in n+1 -> StallE=0, BubbleM=1, StallCount=0; x0 producer/consumer (Rd=0, Rs=0) -> no stall, Forward=00.
- Preload StallCount to max via 2^CNT_W-1 stalls (CNT_W=4 in bench) -> further stalls hold at 15; assert rst_n low mid-stall -> StallE=0 and StallCount=0 immediately.
